// File: rtl/plab5_mcore_mem_net_responder.sv
// plab5_mcore_mem_net_responder
//
// Memory-bank endpoint on the far side of the memory request/response ring.
// Accepts one request per cycle, services it against a local word-addressed
// SRAM, and returns exactly one response per request on the next cycle.
// The lower half of the SRAM is non-secure and the upper half is secure.
// Non-secure reads and writes to the secure half are blocked and counted.
//
// Ports:
//   clk, reset        : clock and synchronous active-low reset
//   req_msg_control   : {type[2:0], opaque, addr, len}, MSB first
//   req_msg_data      : write data
//   req_domain        : requester domain (0 = non-secure, 1 = secure)
//   req_val / req_rdy : request handshake
//   resp_msg_control  : {type[2:0], opaque, len}
//   resp_msg_data     : read data (0 for writes/inits and blocked reads)
//   resp_val/resp_rdy : response handshake
//   viol_count        : saturating count of blocked secure-region accesses
module plab5_mcore_mem_net_responder #(
  parameter int p_mem_opaque_nbits = 8,
  parameter int p_mem_addr_nbits   = 32,
  parameter int p_mem_data_nbits   = 32,
  parameter int p_num_entries      = 256
) (
  input  logic                                                clk,
  input  logic                                                reset,
  input  logic [3+p_mem_opaque_nbits+p_mem_addr_nbits+2-1:0] req_msg_control,
  input  logic [p_mem_data_nbits-1:0]                         req_msg_data,
  input  logic                                                req_domain,
  input  logic                                                req_val,
  output logic                                                req_rdy,
  output logic [3+p_mem_opaque_nbits+2-1:0]                   resp_msg_control,
  output logic [p_mem_data_nbits-1:0]                         resp_msg_data,
  output logic                                                resp_val,
  input  logic                                                resp_rdy,
  output logic [7:0]                                          viol_count
);

  localparam int o   = p_mem_opaque_nbits;
  localparam int a   = p_mem_addr_nbits;
  localparam int d   = p_mem_data_nbits;
  localparam int l   = 2;
  localparam int ix  = $clog2(p_num_entries);
  localparam int rqc = 3 + o + a + l;
  localparam int rsc = 3 + o + l;

  typedef enum logic {IDLE, RESP} state_t;

  state_t         state_q, state_d;
  logic [rsc-1:0] resp_ctrl_q, resp_ctrl_d;
  logic [d-1:0]   resp_data_q;
  logic [7:0]     viol_count_q, viol_count_d;

  logic [d-1:0]   mem [p_num_entries];

  // Request field decode
  logic [2:0]    req_type;
  logic [o-1:0]  req_opaque;
  logic [a-1:0]  req_addr;
  logic [l-1:0]  req_len;
  logic [ix-1:0] idx;

  assign req_type   = req_msg_control[rqc-1 -: 3];
  assign req_opaque = req_msg_control[l+a+o-1 -: o];
  assign req_addr   = req_msg_control[l+a-1 -: a];
  assign req_len    = req_msg_control[l-1:0];
  assign idx        = req_addr[ix+1:2];

  // Byte offset and address bits above the SRAM range are don't-care.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{req_addr[a-1:ix+2], req_addr[1:0]};

  logic is_write, is_init, is_read, is_secure, viol, xfer, wr_en;

  assign is_write  = (req_type == 3'd1);
  assign is_init   = (req_type == 3'd2);
  assign is_read   = !(is_write || is_init);   // unknown types behave as reads
  assign is_secure = idx[ix-1];
  // Init is the trusted preload path and bypasses the domain check.
  assign viol      = !req_domain && is_secure && !is_init;
  assign xfer      = req_val && req_rdy;
  assign wr_en     = xfer && (is_write || is_init) && !viol;

  // Byte enables: len==0 means full word, len==n means the low n bytes.
  logic [3:0] be;
  for (genvar gi = 0; gi < 4; gi++) begin : g_be
    assign be[gi] = (req_len == 2'd0) || (req_len > 2'(gi));
  end

  // Handshake / next-state logic. req_rdy is forced low during reset so no
  // request is consumed while the block is being cleared.
  always_comb begin
    state_d      = state_q;
    req_rdy      = 1'b0;
    resp_val     = 1'b0;
    resp_ctrl_d  = resp_ctrl_q;
    viol_count_d = viol_count_q;

    case (state_q)
      IDLE: begin
        req_rdy = reset;
        if (xfer) state_d = RESP;
      end
      RESP: begin
        resp_val = 1'b1;
        req_rdy  = reset && resp_rdy;
        if (resp_rdy) state_d = req_val ? RESP : IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (xfer) begin
      resp_ctrl_d = {req_type, req_opaque, req_len};
      if (viol && viol_count_q != 8'hFF) viol_count_d = viol_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      resp_ctrl_q  <= '0;
      viol_count_q <= '0;
    end else begin
      state_q      <= state_d;
      resp_ctrl_q  <= resp_ctrl_d;
      viol_count_q <= viol_count_d;
    end
  end

  // SRAM write port; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][b*8 +: 8] <= req_msg_data[b*8 +: 8];
      end
    end
  end

  // Registered SRAM read doubles as the response data register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      resp_data_q <= '0;
    end else if (xfer) begin
      resp_data_q <= (is_read && !viol) ? mem[idx] : '0;
    end
  end

  assign resp_msg_control = resp_ctrl_q;
  assign resp_msg_data    = resp_data_q;
  assign viol_count       = viol_count_q;

endmodule

// File: tb/tb_plab5_mcore_mem_net_responder.sv
// Directed testbench for plab5_mcore_mem_net_responder.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_plab5_mcore_mem_net_responder;

  logic        clk;
  logic        reset;
  logic [44:0] req_msg_control;
  logic [31:0] req_msg_data;
  logic        req_domain;
  logic        req_val;
  logic        req_rdy;
  logic [12:0] resp_msg_control;
  logic [31:0] resp_msg_data;
  logic        resp_val;
  logic        resp_rdy;
  logic [7:0]  viol_count;

  int tests = 0;
  int fails = 0;

  plab5_mcore_mem_net_responder dut (
    .clk              (clk),
    .reset            (reset),
    .req_msg_control  (req_msg_control),
    .req_msg_data     (req_msg_data),
    .req_domain       (req_domain),
    .req_val          (req_val),
    .req_rdy          (req_rdy),
    .resp_msg_control (resp_msg_control),
    .resp_msg_data    (resp_msg_data),
    .resp_val         (resp_val),
    .resp_rdy         (resp_rdy),
    .viol_count       (viol_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Present a request at a falling edge, wait for acceptance, and return
  // at the falling edge right after the accepting rising edge.
  task automatic do_req(input logic [2:0] t, input logic [7:0] op, input logic [31:0] ad,
                        input logic [1:0] ln, input logic [31:0] dt, input logic dom);
    int guard;
    req_msg_control = {t, op, ad, ln};
    req_msg_data    = dt;
    req_domain      = dom;
    req_val         = 1'b1;
    guard = 0;
    while (!req_rdy && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!req_rdy) begin
      tests++; fails++;
      $display("FAIL req_accept_timeout: req_rdy=%0b required=1", req_rdy);
    end
    @(negedge clk);
    req_val = 1'b0;
  endtask

  // Stream n violating writes (domain 0, secure idx 200) back to back.
  task automatic stream_viol(input int n);
    int acc;
    int guard;
    req_msg_control = {3'd1, 8'hEE, 32'h0000_0320, 2'd0};
    req_msg_data    = 32'h5555_AAAA;
    req_domain      = 1'b0;
    req_val         = 1'b1;
    acc = 0;
    guard = 0;
    while (acc < n && guard < n + 20) begin
      if (req_rdy) acc++;
      @(negedge clk);
      guard++;
    end
    req_val = 1'b0;
    if (acc != n) begin
      tests++; fails++;
      $display("FAIL stream_viol_accepts: got=%0d required=%0d", acc, n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; resp_rdy = 1'b1; req_val = 1'b0;
    req_msg_control = '0; req_msg_data = '0; req_domain = 1'b0;
    repeat (2) @(negedge clk);
    tests++; if (resp_val !== 1'b0) begin fails++; $display("FAIL reset_resp_val: got=%0b required=0", resp_val); end
    tests++; if (req_rdy !== 1'b0) begin fails++; $display("FAIL reset_req_rdy: got=%0b required=0", req_rdy); end
    tests++; if (viol_count !== 8'd0) begin fails++; $display("FAIL reset_viol_count: got=%0d required=0", viol_count); end
    tests++; if (resp_msg_control !== 13'd0) begin fails++; $display("FAIL reset_resp_ctrl: got=%h required=0", resp_msg_control); end
    tests++; if (resp_msg_data !== 32'd0) begin fails++; $display("FAIL reset_resp_data: got=%h required=0", resp_msg_data); end
    reset = 1'b1;
    @(negedge clk);
    tests++; if (req_rdy !== 1'b1) begin fails++; $display("FAIL idle_req_rdy: got=%0b required=1", req_rdy); end
    $display("[TB] reset checked");
  endtask

  task automatic test_init_read();
    do_req(3'd2, 8'h11, 32'h0000_0204, 2'd0, 32'hDEAD_BEEF, 1'b0);
    tests++; if (resp_val !== 1'b1) begin fails++; $display("FAIL init_resp_val: got=%0b required=1", resp_val); end
    tests++; if (resp_msg_control !== {3'd2, 8'h11, 2'd0}) begin fails++; $display("FAIL init_resp_ctrl: got=%h required=%h", resp_msg_control, {3'd2, 8'h11, 2'd0}); end
    tests++; if (resp_msg_data !== 32'd0) begin fails++; $display("FAIL init_resp_data: got=%h required=0", resp_msg_data); end
    do_req(3'd0, 8'h5A, 32'h0000_0204, 2'd0, 32'h0, 1'b1);
    tests++; if (resp_val !== 1'b1) begin fails++; $display("FAIL read_latency: resp_val=%0b required=1", resp_val); end
    tests++; if (resp_msg_control !== {3'd0, 8'h5A, 2'd0}) begin fails++; $display("FAIL read_resp_ctrl: got=%h required=%h", resp_msg_control, {3'd0, 8'h5A, 2'd0}); end
    tests++; if (resp_msg_data !== 32'hDEAD_BEEF) begin fails++; $display("FAIL read_resp_data: got=%h required=deadbeef", resp_msg_data); end
    tests++; if (viol_count !== 8'd0) begin fails++; $display("FAIL init_viol_count: got=%0d required=0", viol_count); end
    $display("[TB] init/read idx 129 data=%h", resp_msg_data);
  endtask

  task automatic test_violation();
    do_req(3'd2, 8'h20, 32'h0000_0208, 2'd0, 32'h0, 1'b0);
    tests++; if (viol_count !== 8'd0) begin fails++; $display("FAIL viol_init_skip: got=%0d required=0", viol_count); end
    do_req(3'd1, 8'h21, 32'h0000_0208, 2'd0, 32'h1234_5678, 1'b0);
    tests++; if (resp_val !== 1'b1 || resp_msg_control !== {3'd1, 8'h21, 2'd0}) begin fails++; $display("FAIL viol_write_resp: val=%0b ctrl=%h required val=1 ctrl=%h", resp_val, resp_msg_control, {3'd1, 8'h21, 2'd0}); end
    tests++; if (viol_count !== 8'd1) begin fails++; $display("FAIL viol_write_count: got=%0d required=1", viol_count); end
    do_req(3'd0, 8'h22, 32'h0000_0208, 2'd0, 32'h0, 1'b0);
    tests++; if (resp_val !== 1'b1 || resp_msg_data !== 32'd0) begin fails++; $display("FAIL viol_read_data: val=%0b data=%h required val=1 data=0", resp_val, resp_msg_data); end
    tests++; if (viol_count !== 8'd2) begin fails++; $display("FAIL viol_read_count: got=%0d required=2", viol_count); end
    do_req(3'd0, 8'h23, 32'h0000_0208, 2'd0, 32'h0, 1'b1);
    tests++; if (resp_msg_data !== 32'd0) begin fails++; $display("FAIL secure_read_unchanged: got=%h required=0", resp_msg_data); end
    tests++; if (viol_count !== 8'd2) begin fails++; $display("FAIL secure_read_count: got=%0d required=2", viol_count); end
    $display("[TB] violation count=%0d", viol_count);
  endtask

  task automatic test_partial_write();
    do_req(3'd1, 8'h30, 32'h0000_0014, 2'd0, 32'hAABB_CCDD, 1'b0);
    do_req(3'd1, 8'h31, 32'h0000_0014, 2'd2, 32'h0000_1122, 1'b0);
    tests++; if (resp_msg_control !== {3'd1, 8'h31, 2'd2}) begin fails++; $display("FAIL partial_len_echo: got=%h required=%h", resp_msg_control, {3'd1, 8'h31, 2'd2}); end
    do_req(3'd0, 8'h32, 32'h0000_0014, 2'd0, 32'h0, 1'b0);
    tests++; if (resp_msg_data !== 32'hAABB_1122) begin fails++; $display("FAIL partial_len2: got=%h required=aabb1122", resp_msg_data); end
    do_req(3'd1, 8'h33, 32'h0000_0016, 2'd1, 32'h7777_7799, 1'b0);
    do_req(3'd5, 8'h34, 32'h0000_0015, 2'd0, 32'h0, 1'b0);
    tests++; if (resp_msg_data !== 32'hAABB_1199) begin fails++; $display("FAIL partial_len1: got=%h required=aabb1199", resp_msg_data); end
    tests++; if (resp_msg_control !== {3'd5, 8'h34, 2'd0}) begin fails++; $display("FAIL odd_type_echo: got=%h required=%h", resp_msg_control, {3'd5, 8'h34, 2'd0}); end
    tests++; if (viol_count !== 8'd2) begin fails++; $display("FAIL nonsecure_no_viol: got=%0d required=2", viol_count); end
    $display("[TB] partial write data=%h", resp_msg_data);
  endtask

  task automatic test_backpressure();
    int cnt;
    @(negedge clk);
    resp_rdy = 1'b0;
    do_req(3'd0, 8'h40, 32'h0000_0014, 2'd0, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (resp_val !== 1'b1 || req_rdy !== 1'b0 || resp_msg_control !== {3'd0, 8'h40, 2'd0} || resp_msg_data !== 32'hAABB_1199) begin
        fails++;
        $display("FAIL backpressure_hold[%0d]: val=%0b rdy=%0b ctrl=%h data=%h required val=1 rdy=0 ctrl=%h data=aabb1199",
                 i, resp_val, req_rdy, resp_msg_control, resp_msg_data, {3'd0, 8'h40, 2'd0});
      end
      @(negedge clk);
    end
    resp_rdy = 1'b1;
    cnt = 0;
    repeat (4) begin
      if (resp_val) cnt++;
      @(negedge clk);
    end
    tests++; if (cnt != 1) begin fails++; $display("FAIL backpressure_release: responses=%0d required=1", cnt); end
    $display("[TB] backpressure released, responses=%0d", cnt);
  endtask

  task automatic test_back_to_back();
    resp_rdy = 1'b1;
    req_msg_data = 32'h0;
    req_domain = 1'b0;
    for (int i = 0; i <= 8; i++) begin
      if (i > 0) begin
        tests++;
        if (resp_val !== 1'b1 || resp_msg_control !== {3'd0, 8'(i - 1), 2'd0} || resp_msg_data !== 32'hAABB_1199) begin
          fails++;
          $display("FAIL stream_resp[%0d]: val=%0b ctrl=%h data=%h required val=1 ctrl=%h data=aabb1199",
                   i - 1, resp_val, resp_msg_control, resp_msg_data, {3'd0, 8'(i - 1), 2'd0});
        end
      end
      if (i < 8) begin
        tests++; if (req_rdy !== 1'b1) begin fails++; $display("FAIL stream_req_rdy[%0d]: got=%0b required=1", i, req_rdy); end
        req_msg_control = {3'd0, 8'(i), 32'h0000_0014, 2'd0};
        req_val = 1'b1;
      end else begin
        req_val = 1'b0;
      end
      @(negedge clk);
    end
    tests++; if (resp_val !== 1'b0) begin fails++; $display("FAIL stream_drain: resp_val=%0b required=0", resp_val); end
    $display("[TB] streamed 8 reads");
  endtask

  task automatic test_saturation();
    stream_viol(252);
    tests++; if (viol_count !== 8'd254) begin fails++; $display("FAIL viol_count_254: got=%0d required=254", viol_count); end
    stream_viol(8);
    tests++; if (viol_count !== 8'd255) begin fails++; $display("FAIL viol_count_sat: got=%0d required=255", viol_count); end
    $display("[TB] saturation viol_count=%0d", viol_count);
  endtask

  task automatic test_reset_pending();
    int cnt;
    @(negedge clk);
    resp_rdy = 1'b0;
    do_req(3'd0, 8'h77, 32'h0000_0014, 2'd0, 32'h0, 1'b0);
    tests++; if (resp_val !== 1'b1) begin fails++; $display("FAIL pending_before_reset: resp_val=%0b required=1", resp_val); end
    reset = 1'b0;
    @(negedge clk);
    tests++; if (resp_val !== 1'b0) begin fails++; $display("FAIL reset_pending_val: got=%0b required=0", resp_val); end
    tests++; if (viol_count !== 8'd0) begin fails++; $display("FAIL reset_pending_viol: got=%0d required=0", viol_count); end
    tests++; if (req_rdy !== 1'b0) begin fails++; $display("FAIL reset_pending_rdy: got=%0b required=0", req_rdy); end
    reset = 1'b1;
    resp_rdy = 1'b1;
    cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (resp_val) cnt++;
    end
    tests++; if (cnt != 0) begin fails++; $display("FAIL reset_no_stale_resp: responses=%0d required=0", cnt); end
    $display("[TB] reset with pending response checked");
  endtask

  initial begin
    test_reset();
    test_init_read();
    test_violation();
    test_partial_write();
    test_backpressure();
    test_back_to_back();
    test_saturation();
    test_reset_pending();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/plab5_mcore_mem_net_responder.md
Name: plab5_mcore_mem_net_responder

Overview:
- Cache/memory-bank endpoint sitting on the far side of the memory request/response ring network.
- Consumes split control/data request messages plus the per-request domain bit delivered by the request network.
- Services them against a local word-addressed SRAM with domain-based access checking.
- Injects split control/data response messages into the response network.

Parameters:
- p_mem_opaque_nbits, 8: request/response opaque field width (o)
- p_mem_addr_nbits, 32: request address width (a)
- p_mem_data_nbits, 32: data width (d); fixed at 32 for this block
- p_num_entries, 256: SRAM depth in words, power of 2, at least 4. Lower half is non-secure; upper half is secure.
- Derived: l = 2 (len width); ix = $clog2(p_num_entries); rqc = 3+o+a+l; rsc = 3+o+l

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-low reset; state clears on the rising clk edge while reset==0
- req_msg_control  in  rqc  {type[2:0], opaque, addr, len}, MSB first
- req_msg_data  in  d  write data
- req_domain  in  1  requester domain; 0 = non-secure, 1 = secure
- req_val  in  1  request valid
- req_rdy  out  1  request ready
- resp_msg_control  out  rsc  {type[2:0], opaque, len}
- resp_msg_data  out  d  read data
- resp_val  out  1  response valid
- resp_rdy  in  1  response ready
- viol_count  out  8  saturating count of blocked non-secure accesses to the secure region

Behaviour:
- Types: 0 = read, 1 = write, 2 = init. Any other type is treated as read.
- Word index = addr[ix+1:2]. addr[1:0] is ignored. Secure region = index MSB equals 1.
- Transfer occurs on a cycle with val && rdy. Inputs are sampled only at transfer.
- FSM has two states: IDLE and RESP. Reset state is IDLE.
  - IDLE: req_rdy=1, resp_val=0. A request transfer loads the response register, performs the SRAM access in the same edge, and moves to RESP.
  - RESP: resp_val=1. req_rdy = resp_rdy, which makes the block a full-throughput pipe.
    - resp_rdy && req_val: response leaves and the new request is accepted on the same edge; stay in RESP.
    - resp_rdy && !req_val: go to IDLE.
    - !resp_rdy: hold all response outputs stable.
- Latency: response is valid on the cycle after request acceptance. Sustained throughput is 1 per cycle when resp_rdy is held at 1.
- Access rules:
  - Read: resp data = mem[idx].
  - Write: len==0 writes all 4 bytes; len==n (1..3) writes bytes [n-1:0] only. Resp data = 0.
  - Init: identical to write, but the domain check is skipped.
- Domain check: req_domain==0 and idx in the secure region, for a read or write.
  - Read returns data 0.
  - Write is dropped; memory is unchanged.
  - A normal response is still produced.
  - viol_count increments by 1 and saturates at 255.
- req_domain==1 may access both regions.
- Response control: type and opaque are echoed from the request; len is echoed; the response carries no domain.
- Read-after-write: a read accepted the cycle after a write to the same index returns the new data. The write commits at the accepting edge.
- Reset values: resp_val=0, req_rdy=0 while reset==0, resp_msg_control=0, resp_msg_data=0, viol_count=0. SRAM contents are not reset.
- Reset asserted mid-transaction discards the pending response. No response is produced after reset is released.
- resp_msg_* hold their last value when resp_val==0.

Test Plan:
- Reset then init, non-secure domain: type=2, addr 0x0000_0204 (idx 129), data 0xDEADBEEF, domain 0. Then read with domain 1, opaque 0x5A. Expect resp {type 0, opaque 0x5A, len 0}, data 0xDEADBEEF, arriving 1 cycle after acceptance; viol_count=0.
- Secure-region violation: domain 0 write 0x12345678 to idx 130, then domain 0 read of idx 130. Expect both responses valid, read data 0, viol_count=2. A domain 1 read of idx 130 returns the init value, 0.
- Partial write: full write 0xAABBCCDD to idx 5, then write len=2 data 0x00001122, then read. Expect 0xAABB1122.
- Backpressure: hold resp_rdy=0 for 3 cycles after a read is accepted. Expect resp_val held at 1, outputs stable, req_rdy=0. Release resp_rdy and expect exactly one response.
- Streaming: 8 back-to-back reads with opaque 0..7, resp_rdy=1, val continuous. Expect req_rdy=1 throughout and 8 responses on consecutive cycles in order with matching opaques.
- Reset and saturation:
  - 260 violating accesses: expect viol_count to stop at 255.
  - Assert reset with resp pending: expect resp_val=0 and viol_count=0 on the next cycle.
